store_unit_ctrl: RTL

Sequences S-type store transactions between the core datapath and data memory. It accepts one store per valid/ready handshake, using the computed effective address and the raw rs2 value. It checks alignment and funct3, and generates byte enables and lane-replicated write data. It then drives a req/gnt/ack memory handshake with a timeout and reports completion or error to the pipeline as one-cycle pulses.

---
 rtl/store_unit_ctrl_pkg.sv | 26 ++
 rtl/store_unit_ctrl_lane_align.sv | 51 +++++
 rtl/store_unit_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/store_unit_ctrl_pkg.sv
// rtl/store_unit_ctrl_pkg.sv - shared constants and FSM state type for the store unit
//
// Purpose : store opcode, funct3 store widths, error codes and the controller
//           state enum, imported by store_lane_align and store_unit_ctrl.
// Ports   : none (package).

package store_pkg;

   localparam logic [6:0] OPC_STORE    = 7'b0100011;

   localparam logic [2:0] F3_SB        = 3'b000;
   localparam logic [2:0] F3_SH        = 3'b001;
   localparam logic [2:0] F3_SW        = 3'b010;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

endpackage

// File: rtl/store_unit_ctrl_lane_align.sv
// rtl/store_unit_ctrl_lane_align.sv - combinational byte-lane steering and store checks
//
// Purpose : from funct3 and the low address bits, produce byte enables,
//           lane-replicated write data and the misaligned / illegal flags.
// Ports   : i_funct3     store width (SB/SH/SW)
//           i_addr_lo    effective address bits [1:0]
//           i_data       raw rs2 value
//           o_be         byte enables, bit i = byte lane i
//           o_wdata      write data replicated across lanes
//           o_misaligned SH on odd address or SW not word aligned
//           o_illegal    funct3 is not a store width

module store_lane_align
   import store_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic        o_illegal
);

   always_comb begin
      o_be         = 4'b0000;
      o_wdata      = 32'h0;
      o_misaligned = 1'b0;
      o_illegal    = 1'b0;
      case (i_funct3)
         F3_SB: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_data[7:0]}};
         end
         F3_SH: begin
            o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_data[15:0]}};
            o_misaligned = i_addr_lo[0];
         end
         F3_SW: begin
            o_be         = 4'b1111;
            o_wdata      = i_data;
            o_misaligned = |i_addr_lo;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_unit_ctrl.sv
// rtl/store_unit_ctrl.sv - S-type store sequencer with req/gnt/ack memory handshake
//
// Purpose : accepts one store per valid/ready handshake, checks it, captures
//           word address / byte enables / replicated data, runs the memory
//           handshake under a timeout and reports done / err as 1-cycle pulses.
// Ports   : i_clk, i_rst_n              clock, async active-low reset
//           i_st_valid, o_st_ready      request handshake
//           i_st_funct3/addr/data       store width, effective address, rs2
//           o_mem_req/addr/wdata/be     memory request and payload
//           i_mem_gnt, i_mem_ack        memory accept / write commit
//           o_busy                      not in IDLE
//           o_done, o_err, o_err_code   completion / abort pulse and cause

module store_unit_ctrl
   import store_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_st_valid,
   output logic        o_st_ready,
   input  logic [2:0]  i_st_funct3,
   input  logic [31:0] i_st_addr,
   input  logic [31:0] i_st_data,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_gnt,
   input  logic        i_mem_ack,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [1:0]  o_err_code
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_be;
   logic              r_done;
   logic              r_err;
   logic [1:0]        r_err_code;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_done_nxt;
   logic              w_err_nxt;
   logic [1:0]        w_code_nxt;
   logic              w_capture;

   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic              w_misaligned;
   logic              w_illegal;

   store_lane_align u_lane_align (
      .i_funct3     (i_st_funct3),
      .i_addr_lo    (i_st_addr[1:0]),
      .i_data       (i_st_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_misaligned),
      .o_illegal    (w_illegal)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_mem_be    <= 4'h0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_err_code <= w_code_nxt;
         if (w_capture) begin
            r_mem_addr  <= {i_st_addr[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_be    <= w_be;
         end
      end
   end

   // Illegal funct3 takes precedence over misalignment. gnt+ack together in
   // ISSUE, or ack in WAIT_ACK, beats a timeout landing in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_code_nxt  = ERR_NONE;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_st_valid) begin
               if (w_illegal) begin
                  w_err_nxt  = 1'b1;
                  w_code_nxt = ERR_ILLEGAL;
               end else if (w_misaligned) begin
                  w_err_nxt  = 1'b1;
                  w_code_nxt = ERR_MISALIGN;
               end else begin
                  w_capture   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (i_mem_gnt && i_mem_ack) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == TO_LAST) begin
               w_err_nxt   = 1'b1;
               w_code_nxt  = ERR_TIMEOUT;
               w_state_nxt = ST_IDLE;
            end else if (i_mem_gnt) begin
               w_state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (i_mem_ack) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == TO_LAST) begin
               w_err_nxt   = 1'b1;
               w_code_nxt  = ERR_TIMEOUT;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_st_ready  = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_mem_req   = (r_state == ST_ISSUE);
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_be    = r_mem_be;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_err_code  = r_err_code;

endmodule
